// File: rtl/cpu_stack_ctl.sv
// Operand-stack controller: top-of-stack lives in a register, deeper entries
// spill to / fill from a single-port synchronous SRAM (read data one cycle later).
module cpu_stack_ctl #(
    parameter int WIDTH      = 35,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  st__push_5a,
    input  logic [WIDTH-1:0]      st__to_push_5a,
    input  logic                  st__pop_5a,
    output logic [WIDTH-1:0]      st__tos_5a,
    output logic                  st__tos_valid_5a,
    output logic [DEPTH_LOG2+1:0] st__depth,
    output logic                  stall_2a,
    output logic [DEPTH_LOG2-1:0] sram_addr,
    output logic [WIDTH-1:0]      sram_wdata,
    output logic                  sram_we,
    output logic                  sram_re,
    input  logic [WIDTH-1:0]      sram_rdata,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic                  err_protocol
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [DEPTH_LOG2:0] MEM_CAP = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};

    state_t              state_reg, state_next;
    logic [DEPTH_LOG2:0] mem_cnt_reg, mem_cnt_next;
    logic [WIDTH-1:0]    tos_reg, tos_next;
    logic                tos_valid_reg, tos_valid_next;
    logic                err_ovf_reg, err_ovf_next;
    logic                err_udf_reg, err_udf_next;
    logic                err_prot_reg, err_prot_next;

    logic                push_only, pop_only, push_pop, mem_full, mem_empty;
    logic [DEPTH_LOG2:0] mem_cnt_dec;

    assign push_only   = st__push_5a & ~st__pop_5a;
    assign pop_only    = st__pop_5a & ~st__push_5a;
    assign push_pop    = st__push_5a & st__pop_5a;
    assign mem_full    = (mem_cnt_reg == MEM_CAP);
    assign mem_empty   = (mem_cnt_reg == '0);
    assign mem_cnt_dec = mem_cnt_reg - ONE;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg     <= IDLE;
            mem_cnt_reg   <= '0;
            tos_reg       <= '0;
            tos_valid_reg <= 1'b0;
            err_ovf_reg   <= 1'b0;
            err_udf_reg   <= 1'b0;
            err_prot_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_cnt_reg   <= mem_cnt_next;
            tos_reg       <= tos_next;
            tos_valid_reg <= tos_valid_next;
            err_ovf_reg   <= err_ovf_next;
            err_udf_reg   <= err_udf_next;
            err_prot_reg  <= err_prot_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_cnt_next   = mem_cnt_reg;
        tos_next       = tos_reg;
        tos_valid_next = tos_valid_reg;
        err_ovf_next   = err_ovf_reg;
        err_udf_next   = err_udf_reg;
        err_prot_next  = err_prot_reg;
        case (state_reg)
            FILL: begin
                // Requests during the fill cycle are not accepted.
                tos_next   = sram_rdata;
                state_next = IDLE;
                if (st__push_5a || st__pop_5a) err_prot_next = 1'b1;
            end
            default: begin
                if (push_pop) begin
                    tos_next = st__to_push_5a;
                    if (!tos_valid_reg) begin
                        err_udf_next   = 1'b1;
                        tos_valid_next = 1'b1;
                    end
                end else if (push_only) begin
                    if (!tos_valid_reg) begin
                        tos_next       = st__to_push_5a;
                        tos_valid_next = 1'b1;
                    end else if (!mem_full) begin
                        tos_next     = st__to_push_5a;
                        mem_cnt_next = mem_cnt_reg + ONE;
                    end else begin
                        err_ovf_next = 1'b1;
                    end
                end else if (pop_only) begin
                    if (!tos_valid_reg) begin
                        err_udf_next = 1'b1;
                    end else if (mem_empty) begin
                        tos_valid_next = 1'b0;
                    end else begin
                        mem_cnt_next = mem_cnt_dec;
                        state_next   = FILL;
                    end
                end
            end
        endcase
    end

    always_comb begin
        stall_2a   = (state_reg == FILL);
        sram_we    = 1'b0;
        sram_re    = 1'b0;
        sram_addr  = '0;
        sram_wdata = tos_reg;
        if (state_reg == IDLE) begin
            if (push_only && tos_valid_reg && !mem_full) begin
                sram_we   = 1'b1;
                sram_addr = mem_cnt_reg[DEPTH_LOG2-1:0];
            end else if (pop_only && tos_valid_reg && !mem_empty) begin
                sram_re   = 1'b1;
                sram_addr = mem_cnt_dec[DEPTH_LOG2-1:0];
            end
        end
    end

    assign st__tos_5a       = tos_reg;
    assign st__tos_valid_5a = tos_valid_reg;
    assign st__depth        = {1'b0, mem_cnt_reg} + {{(DEPTH_LOG2+1){1'b0}}, tos_valid_reg};
    assign err_overflow     = err_ovf_reg;
    assign err_underflow    = err_udf_reg;
    assign err_protocol     = err_prot_reg;

endmodule
